// File: rtl/fnd_pkg.sv
// Shared constants and types for the FND scan capture monitor.
package fnd_pkg;

    // Active-low 7-segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low one-hot digit enables; bit0 is the rightmost digit
    localparam logic [3:0] COM_D0  = 4'hE;
    localparam logic [3:0] COM_D1  = 4'hD;
    localparam logic [3:0] COM_D2  = 4'hB;
    localparam logic [3:0] COM_D3  = 4'h7;
    localparam logic [3:0] COM_OFF = 4'hF;

    // Stored for blank digits and for undecodable patterns
    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_HELD
    } scan_state_t;

    // True when the enable pattern selects exactly one digit
    function automatic logic com_is_select(input logic [3:0] com);
        return (com == COM_D0) || (com == COM_D1) ||
               (com == COM_D2) || (com == COM_D3);
    endfunction

    // Digit index of a legal select; callers only use it when com_is_select()
    function automatic logic [1:0] com_index(input logic [3:0] com);
        logic [1:0] idx;
        case (com)
            COM_D1:  idx = 2'd1;
            COM_D2:  idx = 2'd2;
            COM_D3:  idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/fnd_seg_decode.sv
// Combinational active-low segment pattern to BCD decoder.
module fnd_seg_decode
    import fnd_pkg::*;
(
    input  logic [7:0] seg,
    output logic       valid,
    output logic [3:0] bcd,
    output logic       dp
);

    // Blank is a legal code that maps to BLANK_CODE; anything unknown is flagged invalid
    always_comb begin
        valid = 1'b1;
        bcd   = BLANK_CODE;
        case (seg[6:0])
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: bcd = BLANK_CODE;
            default:   valid = 1'b0;
        endcase
        dp = ~seg[7];
    end

endmodule

// File: rtl/fnd_scan_capture.sv
// Receive-side monitor for a 4-digit multiplexed FND bus: settles each
// digit strobe, decodes it and publishes complete 4-digit frames.
module fnd_scan_capture
    import fnd_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  fnd_com,
    input  logic [7:0]  fnd_data,
    output logic [15:0] digits,
    output logic [3:0]  dps,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        com_err,
    output logic        stalled
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_PREV = TW'(TIMEOUT_CYCLES - 1);

    logic [3:0]      com_q;
    logic [7:0]      data_q;
    scan_state_t     state;
    logic [SW-1:0]   settle_cnt;
    logic [TW-1:0]   stall_cnt;
    logic [3:0][3:0] shadow_bcd;
    logic [3:0]      shadow_dp;
    logic [3:0]      cap_mask;

    logic            in_change;
    logic            next_select;
    logic            capture;
    logic            frame_done;
    logic [1:0]      cap_idx;
    logic            dec_valid;
    logic [3:0]      dec_bcd;
    logic            dec_dp;

    // Register the bus once; everything downstream works on the _q copies
    always_ff @(posedge clk) begin
        if (!reset) begin
            com_q  <= COM_OFF;
            data_q <= 8'hFF;
        end else begin
            com_q  <= fnd_com;
            data_q <= fnd_data;
        end
    end

    // The incoming value differs from the registered one, so the _q values
    // change on this edge; treating that as the restart point makes the
    // first cycle of a new value count as stable cycle 0.
    assign in_change   = (fnd_com != com_q) || (fnd_data != data_q);
    assign next_select = com_is_select(fnd_com);

    // Capture fires on the last settle cycle even if the bus changes on the
    // same edge: the value already was stable for the full window.
    assign capture    = (state == ST_SETTLE) && (settle_cnt == SETTLE_LAST);
    assign frame_done = (cap_mask == 4'hF);
    assign cap_idx    = com_index(com_q);

    fnd_seg_decode u_dec (
        .seg   (data_q),
        .valid (dec_valid),
        .bcd   (dec_bcd),
        .dp    (dec_dp)
    );

    // Scan FSM: restart settling on any bus change, hold after capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_WAIT;
            settle_cnt <= '0;
            com_err    <= 1'b0;
        end else begin
            com_err <= (fnd_com != com_q) && !next_select && (fnd_com != COM_OFF);
            if (in_change) begin
                settle_cnt <= '0;
                state      <= next_select ? ST_SETTLE : ST_WAIT;
            end else if (capture) begin
                state <= ST_HELD;
            end else if (state == ST_SETTLE) begin
                settle_cnt <= settle_cnt + SW'(1);
            end
        end
    end

    // Shadow capture and frame publish; a full mask publishes one cycle after
    // the completing capture and is cleared on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_bcd  <= '0;
            shadow_dp   <= '0;
            cap_mask    <= '0;
            digits      <= '0;
            dps         <= '0;
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
        end else begin
            seg_err     <= capture && !dec_valid;
            frame_valid <= frame_done;
            if (capture) begin
                shadow_bcd[cap_idx] <= dec_bcd;
                shadow_dp[cap_idx]  <= dec_dp;
            end
            if (frame_done) begin
                digits <= shadow_bcd;
                dps    <= shadow_dp;
            end
            cap_mask <= (frame_done ? 4'h0 : cap_mask) |
                        (capture ? (4'b0001 << cap_idx) : 4'h0);
        end
    end

    // Idle watchdog: saturating count of cycles since the last capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
            stalled   <= 1'b0;
        end else if (capture) begin
            stall_cnt <= '0;
            stalled   <= 1'b0;
        end else if (stall_cnt != TIMEOUT_MAX) begin
            stall_cnt <= stall_cnt + TW'(1);
            stalled   <= (stall_cnt == TIMEOUT_PREV);
        end
    end

endmodule
